char_class_repeat: RTL and testbench



---
 rtl/char_class_repeat.sv | 85 ++++++++
 tb/tb_char_class_repeat.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/char_class_repeat.sv
// char_class_repeat: regex cell for [class]{MIN_REP,MAX_REP}, one state bit per repetition count.
// Optional macro REGEX_CASE_FOLD_EN enables ASCII case-insensitive comparison (CHAR_W=8 only).
module char_class_repeat #(
  parameter int CHAR_W      = 8,
  parameter int N_ALT       = 2,
  parameter     CLASS_CHARS = {8'h62, 8'h61},
  parameter bit NEGATE      = 1'b0,
  parameter int MIN_REP     = 2,
  parameter int MAX_REP     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i,
  input  logic [CHAR_W-1:0] i_c,
  input  logic              i_v,
  output logic              o,
  output logic              busy
);

  if (MIN_REP < 1) begin : g_err_min
    $error("char_class_repeat: MIN_REP must be >= 1");
  end
  if (MAX_REP < MIN_REP) begin : g_err_max
    $error("char_class_repeat: MAX_REP must be >= MIN_REP");
  end
  if (N_ALT < 1) begin : g_err_nalt
    $error("char_class_repeat: N_ALT must be >= 1");
  end
  if ($bits(CLASS_CHARS) != N_ALT * CHAR_W) begin : g_err_width
    $error("char_class_repeat: CLASS_CHARS width must be N_ALT*CHAR_W");
  end

`ifdef REGEX_CASE_FOLD_EN
  localparam bit                FOLD     = (CHAR_W == 8);
  localparam logic [CHAR_W-1:0] LC_LO    = CHAR_W'(8'h61);
  localparam logic [CHAR_W-1:0] LC_HI    = CHAR_W'(8'h7A);
  localparam logic [CHAR_W-1:0] UC_LO    = CHAR_W'(8'h41);
  localparam logic [CHAR_W-1:0] UC_HI    = CHAR_W'(8'h5A);
  localparam logic [CHAR_W-1:0] CASE_BIT = CHAR_W'(8'h20);

  if (!FOLD) begin : g_fold_warn
    $warning("char_class_repeat: case folding needs CHAR_W=8, folding disabled");
  end

  // Only letters are folded, so punctuation differing in bit 5 stays distinct.
  function automatic logic [CHAR_W-1:0] f_fold(input logic [CHAR_W-1:0] x);
    if (FOLD && (((x >= LC_LO) && (x <= LC_HI)) || ((x >= UC_LO) && (x <= UC_HI))))
      return x & ~CASE_BIT;
    return x;
  endfunction
`else
  function automatic logic [CHAR_W-1:0] f_fold(input logic [CHAR_W-1:0] x);
    return x;
  endfunction
`endif

  logic [N_ALT-1:0]   w_eq;
  logic               w_hit;
  logic [MAX_REP:1]   w_s_nxt;
  logic [MAX_REP:1]   r_s;

  for (genvar k = 0; k < N_ALT; k++) begin : g_eq
    assign w_eq[k] = (f_fold(i_c) == f_fold(CLASS_CHARS[k*CHAR_W +: CHAR_W]));
  end

  assign w_hit = (|w_eq) ^ NEGATE;

  // Count k advances to k+1 on a hit; the top count falls off the end.
  assign w_s_nxt[1] = i & w_hit;
  for (genvar k = 2; k <= MAX_REP; k++) begin : g_shift
    assign w_s_nxt[k] = r_s[k-1] & w_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s <= '0;
    end else if (i_v) begin
      r_s <= w_s_nxt;
    end
  end

  assign o    = |r_s[MAX_REP:MIN_REP];
  assign busy = |r_s;

endmodule

// File: tb/tb_char_class_repeat.sv
// Directed bench for char_class_repeat: class {a,b}{2,3}, plain and negated instances.
module tb_char_class_repeat;

  localparam int MIN_REP = 2;
  localparam int MAX_REP = 3;
  localparam logic [7:0] CA = 8'h61, CB = 8'h62, CC = 8'h63, CD = 8'h64, CX = 8'h78;
  localparam logic [7:0] UA = 8'h41, UB = 8'h42;

  bit         clk;
  logic       reset = 1'b1;
  logic       i     = 1'b0;
  logic       i_v   = 1'b1;
  logic [7:0] i_c   = 8'h00;
  logic       o_d, busy_d, o_n, busy_n;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         tok;
    logic [7:0] c;
  } ev_t;
  ev_t q[$];

  char_class_repeat #(
    .CHAR_W(8), .N_ALT(2), .CLASS_CHARS({8'h62, 8'h61}), .NEGATE(1'b0),
    .MIN_REP(MIN_REP), .MAX_REP(MAX_REP)
  ) u_dut (
    .clk(clk), .reset(reset), .i(i), .i_c(i_c), .i_v(i_v), .o(o_d), .busy(busy_d)
  );

  char_class_repeat #(
    .CHAR_W(8), .N_ALT(2), .CLASS_CHARS({8'h62, 8'h61}), .NEGATE(1'b1),
    .MIN_REP(MIN_REP), .MAX_REP(MAX_REP)
  ) u_neg (
    .clk(clk), .reset(reset), .i(i), .i_c(i_c), .i_v(i_v), .o(o_n), .busy(busy_n)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [7:0] upcase(input logic [7:0] x);
`ifdef REGEX_CASE_FOLD_EN
    if (x >= 8'h61 && x <= 8'h7A) return x - 8'h20;
`endif
    return x;
  endfunction

  function automatic bit hit_m(input logic [7:0] c, input bit neg);
    bit member;
    member = (upcase(c) == upcase(CA)) || (upcase(c) == upcase(CB));
    return member ^ neg;
  endfunction

  // A path is live if some token entered L valid characters ago and all L of them hit.
  function automatic void model(input bit neg, output logic mo, output logic mb);
    bit all;
    int n;
    mo  = 1'b0;
    mb  = 1'b0;
    all = 1'b1;
    n   = q.size();
    for (int L = 1; L <= MAX_REP && L <= n; L++) begin
      all = all && hit_m(q[n-L].c, neg);
      if (all && q[n-L].tok) begin
        mb = 1'b1;
        if (L >= MIN_REP) mo = 1'b1;
      end
    end
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
    end else if (i_v) begin
      q.push_back('{tok: i, c: i_c});
      if (q.size() > 16) void'(q.pop_front());
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic eo, eb;
    model(1'b0, eo, eb);
    chk("cyc_o", o_d, eo);
    chk("cyc_busy", busy_d, eb);
    model(1'b1, eo, eb);
    chk("cyc_neg_o", o_n, eo);
    chk("cyc_neg_busy", busy_n, eb);
  end

  task automatic step(input logic r, input logic t, input logic [7:0] c, input logic v);
    reset = r;
    i     = t;
    i_c   = c;
    i_v   = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_fold;
`ifdef REGEX_CASE_FOLD_EN
    exp_fold = 1'b1;
`else
    exp_fold = 1'b0;
`endif

    // reset held with an active token present
    for (int n = 0; n < 2; n++) begin
      step(1'b1, 1'b1, CA, 1'b1);
      chk("rst_o", o_d, 1'b0);
      chk("rst_busy", busy_d, 1'b0);
    end

    // single token through a,b,a,b: leaves after MAX_REP
    step(1'b0, 1'b1, CA, 1'b1); chk("p1_o", o_d, 1'b0); chk("p1_busy", busy_d, 1'b1);
    step(1'b0, 1'b0, CB, 1'b1); chk("p2_o", o_d, 1'b1); chk("p2_busy", busy_d, 1'b1);
    step(1'b0, 1'b0, CA, 1'b1); chk("p3_o", o_d, 1'b1); chk("p3_busy", busy_d, 1'b1);
    step(1'b0, 1'b0, CB, 1'b1); chk("p4_o", o_d, 1'b0); chk("p4_busy", busy_d, 1'b0);

    // token every cycle; non-hit clears everything
    step(1'b0, 1'b1, CA, 1'b1); chk("c1_o", o_d, 1'b0);
    step(1'b0, 1'b1, CA, 1'b1); chk("c2_o", o_d, 1'b1);
    step(1'b0, 1'b1, CA, 1'b1); chk("c3_o", o_d, 1'b1);
    step(1'b0, 1'b1, CA, 1'b1); chk("c4_o", o_d, 1'b1);
    step(1'b0, 1'b1, CX, 1'b1); chk("c5_o", o_d, 1'b0); chk("c5_busy", busy_d, 1'b0);
    step(1'b0, 1'b1, CA, 1'b1); chk("c6_o", o_d, 1'b0); chk("c6_busy", busy_d, 1'b1);
    step(1'b0, 1'b0, CX, 1'b1); chk("flush_busy", busy_d, 1'b0);

    // stall: i and i_c ignored while i_v=0
    step(1'b0, 1'b1, CA, 1'b1);
    for (int n = 0; n < 3; n++) begin
      step(1'b0, 1'b1, CX, 1'b0);
      chk("stall_o", o_d, 1'b0);
      chk("stall_busy", busy_d, 1'b1);
    end
    step(1'b0, 1'b0, CB, 1'b1); chk("stall_end_o", o_d, 1'b1);
    step(1'b0, 1'b0, CX, 1'b1);

    // negated class
    step(1'b1, 1'b0, CX, 1'b1);
    step(1'b0, 1'b1, CC, 1'b1);
    step(1'b0, 1'b0, CD, 1'b1); chk("neg_cd_o", o_n, 1'b1);
    step(1'b0, 1'b0, CA, 1'b1); chk("neg_flush_busy", busy_n, 1'b0);
    step(1'b0, 1'b1, CC, 1'b1);
    step(1'b0, 1'b0, CA, 1'b1); chk("neg_ca_o", o_n, 1'b0); chk("neg_ca_busy", busy_n, 1'b0);

    // reset mid-run wins over a hit
    step(1'b1, 1'b0, CX, 1'b1);
    step(1'b0, 1'b1, CA, 1'b1);
    step(1'b0, 1'b0, CB, 1'b1); chk("mid_pre_o", o_d, 1'b1);
    step(1'b1, 1'b1, CA, 1'b1); chk("mid_rst_o", o_d, 1'b0); chk("mid_rst_busy", busy_d, 1'b0);

    // uppercase input: matches only with case folding
    step(1'b0, 1'b1, UA, 1'b1); chk("fold_a_busy", busy_d, exp_fold);
    step(1'b0, 1'b0, UB, 1'b1); chk("fold_b_o", o_d, exp_fold);
    step(1'b0, 1'b0, CX, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
